gen_w_sched: RTL and testbench
==============================

// Module: gen_w_sched
// PURPOSE
//  Parametrised SHA-2 message-schedule generator; covers SHA-224/256 (32-bit) and SHA-384/512 (64-bit).
//  Accepts one padded 16-word block via valid/ready; streams W[0..ROUNDS-1] via valid/ready, one word per handshake.
//  Sits between the padder and the round/compression core.
//  Back-pressure and abort support allow the core to stall or flush at any cycle.
// PARAMETERS
//  WORD_W   32   word width; legal values 32 (SHA-256 family) and 64 (SHA-512 family)
//  ROUNDS   64   words emitted per block; legal 64 (WORD_W=32) or 80 (WORD_W=64)
// PORTS
//  clock      in   1           rising-edge clock
//  reset      in   1           synchronous, active-high reset
//  blk_valid  in   1           padded block available
//  blk_ready  out  1           block accepted when blk_valid & blk_ready
//  blk_data   in   16*WORD_W   block; W[0] = blk_data[16*WORD_W-1 -: WORD_W], W[15] = LSB word
//  abort      in   1           synchronous flush of the current block
//  w_valid    out  1           w_data/w_idx/w_last valid
//  w_ready    in   1           consumer accepts word when w_valid & w_ready
//  w_data     out  WORD_W      W[w_idx]
//  w_idx      out  7           index of current word, 0..ROUNDS-1
//  w_last     out  1           high with w_valid when w_idx == ROUNDS-1
//  busy       out  1           high in RUN
// BEHAVIOUR
//  Reset: state=IDLE; blk_ready=1; w_valid=0; w_last=0; busy=0; w_data=0; w_idx=0. Window regs are not reset.
//  States:
//   IDLE: blk_ready=1. On blk_valid:
//    - load window win[0..15] <= W[0..15];
//    - w_idx <= 0; go to RUN.
//   RUN: blk_ready=0; w_valid=1; busy=1; w_data=win[0]. On handshake:
//    - win[i] <= win[i+1] for i<15;
//    - win[15] <= Wnew;
//    - w_idx <= w_idx+1.
//    Handshake with w_last=1 -> IDLE.
//  Latency: block accepted at edge N -> w_valid=1 with W[0] in the cycle after N; one word per cycle when w_ready held high.
//   A 64-word block takes 1 load cycle plus 64 word cycles; the next block may be accepted in the first IDLE cycle.
//  Schedule: Wnew = s1(win[14]) + win[9] + s0(win[1]) + win[0], modulo 2^WORD_W.
//   Computed from the registered window in the same cycle (single adder tree, no carry-out).
//  WORD_W=32: s0 = ROTR7 ^ ROTR18 ^ SHR3;  s1 = ROTR17 ^ ROTR19 ^ SHR10.
//  WORD_W=64: s0 = ROTR1 ^ ROTR8 ^ SHR7;   s1 = ROTR19 ^ ROTR61 ^ SHR6.
//  Stall: w_valid & !w_ready -> w_data, w_idx, w_last and window hold bit-exact; no word dropped or repeated.
//  w_valid, once high, stays high until handshake, abort or reset.
//  abort:
//   - abort=1 in RUN -> next cycle IDLE, w_valid=0, w_idx=0; a handshake in the same cycle is ignored.
//   - abort=1 in IDLE has priority over blk_valid: no block is loaded.
//  reset has priority over abort and all handshakes. Reset mid-RUN -> IDLE next cycle; the partial block is discarded.
//  Illegal parameter combinations are flagged by a simulation-time $error in an initial block.
// TESTING
//  1. 32-bit, block with W0=0x00000001 and all other words 0, w_ready=1:
//     W16=0x00000001, W17=0x00000000, W18=0x0000A000; all 64 words match the golden model.
//  2. 32-bit, "abc" padded block (W0=0x61626380, W15=0x00000018):
//     W0..W63 match the FIPS 180-4 model; w_last only on w_idx=63.
//  3. Random w_ready (50%) over 100 random blocks:
//     - word stream identical to the w_ready=1 run;
//     - data stable while stalled.
//  4. abort asserted at w_idx=20 with a handshake in the same cycle:
//     w_valid=0 next cycle, blk_ready=1, next block starts at w_idx=0.
//  5. reset pulsed at w_idx=40: outputs at reset values next cycle; fresh block accepted afterwards.
//  6. WORD_W=64, ROUNDS=80, "abc" SHA-512 padded block:
//     80 words match the model; back-to-back blocks with no idle gap beyond the load cycle.

Source files
------------

// File: rtl/gen_w_sched.sv
// +----------------------------------------------------------------------------+
// | gen_w_sched: SHA-2 message-schedule generator (SHA-224/256 and 384/512).  |
// | Loads one 16-word block, streams W[0..ROUNDS-1] over valid/ready.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module gen_w_sched #(
  parameter int WORD_W = 32,
  parameter int ROUNDS = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  blk_valid,
  output logic                  blk_ready,
  input  logic [16*WORD_W-1:0]  blk_data,
  input  logic                  abort,
  output logic                  w_valid,
  input  logic                  w_ready,
  output logic [WORD_W-1:0]     w_data,
  output logic [6:0]            w_idx,
  output logic                  w_last,
  output logic                  busy
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;
  localparam logic [6:0] c_LAST_IDX = 7'(ROUNDS - 1);
  localparam bit c_LEGAL = ((WORD_W == 32) && (ROUNDS == 64)) ||
                           ((WORD_W == 64) && (ROUNDS == 80));

  logic [0:0]        r_state;
  logic [6:0]        r_idx;
  logic [WORD_W-1:0] r_win [16];

  logic              w_run;
  logic              w_load;
  logic              w_shift;
  logic              w_is_last;
  logic [WORD_W-1:0] w_s0;
  logic [WORD_W-1:0] w_s1;
  logic [WORD_W-1:0] w_wnew;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  generate
    if (!c_LEGAL) begin : g_bad_params
      initial $error("gen_w_sched: illegal WORD_W=%0d / ROUNDS=%0d", WORD_W, ROUNDS);
    end
    if (WORD_W == 64) begin : g_sha512
      assign w_s0 = rotr(r_win[1], 1)   ^ rotr(r_win[1], 8)   ^ (r_win[1] >> 7);
      assign w_s1 = rotr(r_win[14], 19) ^ rotr(r_win[14], 61) ^ (r_win[14] >> 6);
    end else begin : g_sha256
      assign w_s0 = rotr(r_win[1], 7)   ^ rotr(r_win[1], 18)  ^ (r_win[1] >> 3);
      assign w_s1 = rotr(r_win[14], 17) ^ rotr(r_win[14], 19) ^ (r_win[14] >> 10);
    end
  endgenerate

  assign w_wnew    = w_s1 + r_win[9] + w_s0 + r_win[0];
  assign w_run     = (r_state == S_RUN);
  assign w_is_last = w_run && (r_idx == c_LAST_IDX);
  // abort and reset both suppress any load or shift in the same cycle
  assign w_load    = !reset && !abort && !w_run && blk_valid;
  assign w_shift   = !reset && !abort && w_run && w_ready;

  assign blk_ready = !w_run;
  assign w_valid   = w_run;
  assign busy      = w_run;
  assign w_data    = w_run ? r_win[0] : '0;
  assign w_idx     = r_idx;
  assign w_last    = w_is_last;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_idx   <= 7'd0;
    end else if (abort) begin
      r_state <= S_IDLE;
      r_idx   <= 7'd0;
    end else if (w_load) begin
      r_state <= S_RUN;
      r_idx   <= 7'd0;
    end else if (w_shift) begin
      if (w_is_last) begin
        r_state <= S_IDLE;
        r_idx   <= 7'd0;
      end else begin
        r_idx   <= r_idx + 7'd1;
      end
    end
  end

  // Window carries no reset; it is fully reloaded before it is ever observed.
  always_ff @(posedge clock) begin
    if (w_load) begin
      for (int i = 0; i < 16; i++) r_win[i] <= blk_data[(16-i)*WORD_W-1 -: WORD_W];
    end else if (w_shift) begin
      for (int i = 0; i < 15; i++) r_win[i] <= r_win[i+1];
      r_win[15] <= w_wnew;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gen_w_sched.sv
// +----------------------------------------------------------------------------+
// | tb_gen_w_sched: bench for gen_w_sched, 32-bit and 64-bit instances.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_gen_w_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, bv, ab, wr, sel64;
  logic [1023:0] blk;

  logic        r32, v32, l32, b32;
  logic [31:0] d32;
  logic [6:0]  i32;
  logic        r64, v64, l64, b64;
  logic [63:0] d64;
  logic [6:0]  i64;

  gen_w_sched #(.WORD_W(32), .ROUNDS(64)) u_dut32 (
    .clock(clk), .reset(rst), .blk_valid(bv & !sel64), .blk_ready(r32),
    .blk_data(blk[511:0]), .abort(ab & !sel64), .w_valid(v32), .w_ready(wr),
    .w_data(d32), .w_idx(i32), .w_last(l32), .busy(b32));

  gen_w_sched #(.WORD_W(64), .ROUNDS(80)) u_dut64 (
    .clock(clk), .reset(rst), .blk_valid(bv & sel64), .blk_ready(r64),
    .blk_data(blk), .abort(ab & sel64), .w_valid(v64), .w_ready(wr),
    .w_data(d64), .w_idx(i64), .w_last(l64), .busy(b64));

  logic        m_ready, m_valid, m_last, m_busy;
  logic [63:0] m_data;
  logic [6:0]  m_idx;
  assign m_ready = sel64 ? r64 : r32;
  assign m_valid = sel64 ? v64 : v32;
  assign m_last  = sel64 ? l64 : l32;
  assign m_busy  = sel64 ? b64 : b32;
  assign m_data  = sel64 ? d64 : {32'd0, d32};
  assign m_idx   = sel64 ? i64 : i32;

  int checks = 0;
  int errors = 0;
  logic [63:0] ew  [80];
  logic [63:0] got [80];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference schedule: FIPS 180-4 recurrence over a plain array
  function automatic logic [63:0] ror(input logic [63:0] x, input int n, input bit w64);
    if (w64) return (x >> n) | (x << (64 - n));
    return ((x >> n) | (x << (32 - n))) & 64'hFFFF_FFFF;
  endfunction

  function automatic logic [63:0] sig0(input logic [63:0] x, input bit w64);
    if (w64) return ror(x, 1, 1) ^ ror(x, 8, 1) ^ (x >> 7);
    return ror(x, 7, 0) ^ ror(x, 18, 0) ^ (x >> 3);
  endfunction

  function automatic logic [63:0] sig1(input logic [63:0] x, input bit w64);
    if (w64) return ror(x, 19, 1) ^ ror(x, 61, 1) ^ (x >> 6);
    return ror(x, 17, 0) ^ ror(x, 19, 0) ^ (x >> 10);
  endfunction

  task automatic gen_expected(input logic [1023:0] b, input bit w64);
    logic [63:0] mask;
    int n;
    mask = w64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    n = w64 ? 80 : 64;
    for (int t = 0; t < 16; t++)
      ew[t] = w64 ? b[1023 - 64*t -: 64] : {32'd0, b[511 - 32*t -: 32]};
    for (int t = 16; t < n; t++)
      ew[t] = (sig1(ew[t-2], w64) + ew[t-7] + sig0(ew[t-15], w64) + ew[t-16]) & mask;
  endtask

  task automatic rand_block(output logic [1023:0] b);
    for (int i = 0; i < 32; i++) b[32*i +: 32] = $urandom;
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge.
  task automatic run_block(input logic [1023:0] b, input bit rnd,
                           input int abort_at, input int reset_at, input string tag);
    int  n, k, cyc;
    bit  done, stopped;
    n = sel64 ? 80 : 64;
    k = 0; cyc = 0; done = 0; stopped = 0;
    gen_expected(b, sel64);
    blk = b; bv = 1'b1; ab = 1'b0; wr = 1'b0;
    check({tag, "/blk_ready"}, m_ready, 1);
    @(posedge clk);
    @(negedge clk);
    bv = 1'b0;
    blk = '0;
    while (!done) begin
      check({tag, "/w_valid"}, m_valid, 1);
      check({tag, "/busy"}, m_busy, 1);
      check({tag, "/blk_ready_run"}, m_ready, 0);
      check($sformatf("%s/w_idx%0d", tag, k), m_idx, k);
      check($sformatf("%s/w_data%0d", tag, k), m_data, ew[k]);
      check($sformatf("%s/w_last%0d", tag, k), m_last, (k == n - 1));
      wr = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (k == abort_at) begin ab = 1'b1; wr = 1'b1; end
      if (k == reset_at) rst = 1'b1;
      if (wr) got[k] = m_data;
      @(posedge clk);
      @(negedge clk);
      if (k == abort_at || k == reset_at) begin
        ab = 1'b0; rst = 1'b0; done = 1; stopped = 1;
      end else if (wr) begin
        k++;
        if (k == n) done = 1;
      end
      cyc++;
      if (!done && cyc > 8*n) begin
        check({tag, "/timeout"}, cyc, 8*n);
        done = 1;
      end
    end
    wr = 1'b0;
    check({tag, "/end_valid"}, m_valid, 0);
    check({tag, "/end_ready"}, m_ready, 1);
    check({tag, "/end_busy"}, m_busy, 0);
    check({tag, "/end_last"}, m_last, 0);
    if (stopped) begin
      check({tag, "/end_idx"}, m_idx, 0);
      check({tag, "/end_data"}, m_data, 0);
    end
  endtask

  initial begin
    logic [1023:0] b;
    rst = 1'b1; bv = 1'b0; ab = 1'b0; wr = 1'b0; sel64 = 1'b0; blk = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel64 = 1'(s);
      #1;
      check("rst/blk_ready", m_ready, 1);
      check("rst/w_valid", m_valid, 0);
      check("rst/w_last", m_last, 0);
      check("rst/busy", m_busy, 0);
      check("rst/w_data", m_data, 0);
      check("rst/w_idx", m_idx, 0);
    end
    sel64 = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    b = '0; b[511:480] = 32'h0000_0001;
    run_block(b, 0, -1, -1, "t1");
    check("t1/W16", got[16], 64'h0000_0001);
    check("t1/W17", got[17], 64'h0000_0000);
    check("t1/W18", got[18], 64'h0000_A000);

    b = '0; b[511:480] = 32'h6162_6380; b[31:0] = 32'h0000_0018;
    run_block(b, 0, -1, -1, "t2");
    check("t2/W16", got[16], 64'h6162_6380);
    check("t2/W17", got[17], 64'h000F_0000);

    for (int i = 0; i < 100; i++) begin
      rand_block(b);
      run_block(b, 1, -1, -1, "t3");
    end

    // abort in IDLE must win over blk_valid
    bv = 1'b1; ab = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bv = 1'b0; ab = 1'b0;
    check("idle_abort/w_valid", m_valid, 0);
    check("idle_abort/busy", m_busy, 0);
    check("idle_abort/blk_ready", m_ready, 1);

    rand_block(b);
    run_block(b, 0, 20, -1, "t4");
    rand_block(b);
    run_block(b, 1, -1, -1, "t4_next");

    rand_block(b);
    run_block(b, 0, -1, 40, "t5");
    rand_block(b);
    run_block(b, 0, -1, -1, "t5_next");

    sel64 = 1'b1;
    b = '0; b[1023:960] = 64'h6162_6380_0000_0000; b[63:0] = 64'h18;
    run_block(b, 0, -1, -1, "t6");
    check("t6/W16", got[16], 64'h6162_6380_0000_0000);
    check("t6/W17", got[17], 64'h0003_0000_0000_00C0);
    for (int i = 0; i < 4; i++) begin
      rand_block(b);
      run_block(b, (i >= 2), -1, -1, "t6_b2b");
    end
    rand_block(b);
    run_block(b, 0, 33, -1, "t6_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
